// File: rtl/com_pkg.sv
// Shared front-end constants: canonical NOP encoding and default instruction queue depth.
package com_pkg;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam int          INST_QUEUE_DEPTH = 4;
endpackage

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode1, flushable on redirect.
// Optional same-cycle empty-queue bypass when INST_QUEUE_BYPASS_EN is defined.
module inst_queue
  import com_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = INST_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [WIDTH-1:0]         enq_inst,
  input  logic [WIDTH-1:0]         enq_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [WIDTH-1:0]         deq_inst,
  output logic [WIDTH-1:0]         deq_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0]    LAST_PTR = PW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] NOP_W    = WIDTH'(INST_NOP);

  // Handshake: a transfer happens on a rising edge when valid && ready && !flush.
  logic [WIDTH-1:0] inst_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem   [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty;
  logic bypass;
  logic enq_fire, deq_fire;
  logic do_wr, do_rd;

  always_comb begin
    empty     = (count_q == '0);
    enq_ready = (count_q != FULL_CNT);
    bypass    = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    bypass    = empty & enq_valid & ~flush;
`endif
    deq_valid = ~empty | bypass;

    if (bypass) begin
      deq_inst = enq_inst;
      deq_pc   = enq_pc;
    end else if (!empty) begin
      deq_inst = inst_mem[rd_ptr_q];
      deq_pc   = pc_mem[rd_ptr_q];
    end else begin
      deq_inst = NOP_W;
      deq_pc   = '0;
    end
  end

  always_comb begin
    enq_fire = enq_valid & enq_ready & ~flush;
    deq_fire = deq_valid & deq_ready & ~flush;
    // A bypassed entry consumed in the same cycle never touches storage.
    do_wr    = enq_fire & ~(bypass & deq_ready);
    do_rd    = deq_fire & ~bypass;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      inst_mem[wr_ptr_q] <= enq_inst;
      pc_mem[wr_ptr_q]   <= enq_pc;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus random traffic against a queue model.
module tb_inst_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [31:0] enq_inst = '0;
  logic [31:0] enq_pc = '0;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;

  logic [31:0] m_inst[$];
  logic [31:0] m_pc[$];
  logic [31:0] next_pc = 32'h0;

  inst_queue #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_inst(enq_inst), .enq_pc(enq_pc),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_inst(deq_inst), .deq_pc(deq_pc),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_bypass();
    logic bv;
    bv = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    bv = (m_inst.size() == 0) && enq_valid && !flush;
`endif
    return bv;
  endfunction

  task automatic compare_outputs(input string tag);
    int n;
    logic bv;
    n  = m_inst.size();
    bv = model_bypass();
    check({tag, ".count"}, 64'(count), 64'(n));
    check({tag, ".enq_ready"}, 64'(enq_ready), 64'(n < DEPTH));
    check({tag, ".deq_valid"}, 64'(deq_valid), 64'((n != 0) || bv));
    if (n != 0) begin
      check({tag, ".deq_inst"}, 64'(deq_inst), 64'(m_inst[0]));
      check({tag, ".deq_pc"}, 64'(deq_pc), 64'(m_pc[0]));
    end else if (bv) begin
      check({tag, ".deq_inst"}, 64'(deq_inst), 64'(enq_inst));
      check({tag, ".deq_pc"}, 64'(deq_pc), 64'(enq_pc));
    end else begin
      check({tag, ".deq_inst"}, 64'(deq_inst), 64'(NOP));
      check({tag, ".deq_pc"}, 64'(deq_pc), 64'(0));
    end
  endtask

  task automatic drive(input logic ev, input logic [31:0] inst, input logic [31:0] pc,
                       input logic dr, input logic fl);
    enq_valid = ev;
    enq_inst  = inst;
    enq_pc    = pc;
    deq_ready = dr;
    flush     = fl;
  endtask

  // Checks outputs for the current inputs, then advances one clock and the model with it.
  task automatic tick(input string tag);
    int n;
    logic bv, dv, er, d, e;
    #2;
    compare_outputs(tag);
    n  = m_inst.size();
    bv = model_bypass();
    er = (n < DEPTH);
    dv = (n != 0) || bv;
    @(posedge clk);
    if (flush) begin
      m_inst.delete();
      m_pc.delete();
    end else begin
      d = dv && deq_ready;
      e = enq_valid && er;
      if (!(bv && d)) begin
        if (d) begin
          void'(m_inst.pop_front());
          void'(m_pc.pop_front());
        end
        if (e) begin
          m_inst.push_back(enq_inst);
          m_pc.push_back(enq_pc);
        end
      end
    end
    #1;
  endtask

  task automatic push_pc(input logic dr, input string tag);
    drive(1'b1, $urandom, next_pc, dr, 1'b0);
    tick(tag);
    next_pc += 32'h4;
  endtask

  logic [31:0] prev_pc;

  initial begin
    // Reset state
    #2;
    check("rst.count", 64'(count), 64'(0));
    check("rst.enq_ready", 64'(enq_ready), 64'(1));
    check("rst.deq_valid", 64'(deq_valid), 64'(0));
    check("rst.deq_inst", 64'(deq_inst), 64'(NOP));
    check("rst.deq_pc", 64'(deq_pc), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill with PCs 0,4,8,C while decode stalls
    for (int i = 0; i < 4; i++) push_pc(1'b0, "fill");
    #2;
    check("fill.count", 64'(count), 64'(4));
    check("fill.enq_ready", 64'(enq_ready), 64'(0));
    check("fill.deq_pc", 64'(deq_pc), 64'(0));

    // Full with both sides active: enqueue refused, one dequeue
    drive(1'b1, 32'hdead_beef, 32'h1234, 1'b1, 1'b0);
    #1;
    check("full.enq_ready_same_cycle", 64'(enq_ready), 64'(0));
    tick("full_both");
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    check("full.next_count", 64'(count), 64'(3));
    check("full.next_enq_ready", 64'(enq_ready), 64'(1));
    check("full.next_deq_pc", 64'(deq_pc), 64'(4));

    // Drop to count 2, then steady-state enq+deq for 8 cycles
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tick("drain1");
    prev_pc = m_pc[0];
    for (int i = 0; i < 8; i++) begin
      push_pc(1'b1, "steady");
      check("steady.count", 64'(count), 64'(2));
      check("steady.pc_step", 64'(deq_pc), 64'(prev_pc + 32'h4));
      prev_pc = deq_pc;
    end

    // Count 3 then flush with a competing enqueue
    push_pc(1'b0, "to3");
    drive(1'b1, 32'h1111_1111, 32'h2222, 1'b1, 1'b1);
    tick("flush");
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #2;
    check("flush.count", 64'(count), 64'(0));
    check("flush.deq_valid", 64'(deq_valid), 64'(0));
    check("flush.deq_inst", 64'(deq_inst), 64'(NOP));

    // Empty queue, single enqueue with decode ready
    drive(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    check("empty_enq.same_valid", 64'(deq_valid), 64'(1));
    check("empty_enq.same_inst", 64'(deq_inst), 64'(32'h0050_0093));
`else
    check("empty_enq.same_valid", 64'(deq_valid), 64'(0));
`endif
    tick("empty_enq");
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    check("empty_enq.next_count", 64'(count), 64'(0));
`else
    check("empty_enq.next_valid", 64'(deq_valid), 64'(1));
    check("empty_enq.next_pc", 64'(deq_pc), 64'(32'h100));
`endif
    tick("empty_deq");

    // Asynchronous reset between edges with two entries held
    next_pc = 32'h200;
    push_pc(1'b0, "pre_rst");
    push_pc(1'b0, "pre_rst");
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    check("arst.pre_count", 64'(count), 64'(2));
    rst_n = 1'b0;
    #1;
    m_inst.delete();
    m_pc.delete();
    check("arst.count", 64'(count), 64'(0));
    check("arst.enq_ready", 64'(enq_ready), 64'(1));
    check("arst.deq_valid", 64'(deq_valid), 64'(0));
    check("arst.deq_inst", 64'(deq_inst), 64'(NOP));
    check("arst.deq_pc", 64'(deq_pc), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 60), $urandom, next_pc,
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 4));
      next_pc += 32'h4;
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction and PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  discard all entries (redirect).
REQ-006 SHALL have port enq_valid  input  1  fetch offers an instruction.
REQ-007 SHALL have port enq_ready  output  1  queue accepts this cycle.
REQ-008 SHALL have port enq_inst  input  WIDTH  raw instruction word.
REQ-009 SHALL have port enq_pc  input  WIDTH  instruction PC.
REQ-010 SHALL have port deq_valid  output  1  head entry valid for decode1.
REQ-011 SHALL have port deq_ready  input  1  decode1 consumes head.
REQ-012 SHALL have port deq_inst  output  WIDTH  head instruction, feeds decoder inst_in.
REQ-013 SHALL have port deq_pc  output  WIDTH  head PC.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL be a circular FIFO; read/write pointers wrap from DEPTH-1 to 0.
REQ-016 SHALL enqueue on clk edge when enq_valid && enq_ready && !flush.
REQ-017 SHALL dequeue on clk edge when deq_valid && deq_ready && !flush.
REQ-018 SHALL drive enq_ready = (count < DEPTH), registered-only; no combinational path from deq_ready.
REQ-019 SHALL drive deq_valid = (count != 0) (bypass case per REQ-029).
REQ-020 SHALL drive deq_inst = INST_NOP (32'h00000013) and deq_pc = 0 whenever deq_valid is 0.
REQ-021 SHALL, on simultaneous enqueue and dequeue, keep count unchanged and advance both pointers.
REQ-022 SHALL, when full, deassert enq_ready even if deq_ready is 1 in the same cycle.
REQ-023 SHALL, with flush=1, set count=0 and both pointers=0 at next edge; flush dominates same-cycle enqueue/dequeue, which have no effect.
REQ-024 SHALL give enqueue-to-deq_valid latency of exactly 1 cycle when the queue is empty (without macro).
REQ-025 SHALL preserve program order: dequeue order equals enqueue order.
REQ-026 SHALL hold the head stable while deq_valid && !deq_ready.

Reset
REQ-027 SHALL, on rst_n low (asynchronous), force count=0, pointers=0, enq_ready=1, deq_valid=0, deq_inst=INST_NOP, deq_pc=0; storage array contents need not be reset.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_n deasserts; reset mid-transfer drops all entries.

Configuration
REQ-029 SHALL, with INST_QUEUE_BYPASS_EN defined, present enq_inst/enq_pc on deq_* with deq_valid=1 in the same cycle when the queue is empty and enq_valid=1 and flush=0; if deq_ready=1 the entry is not written, otherwise it is written.
REQ-030 SHALL, without INST_QUEUE_BYPASS_EN, have no combinational path from enq_* to deq_*.

Structure
REQ-031 SHALL take INST_NOP and the default depth constant INST_QUEUE_DEPTH from com_pkg.
REQ-032 SHALL be a single module; no sub-module; storage is an inline register array.

Verification
REQ-033 Reset then 4 enqueues PC 0x0,0x4,0x8,0xC with deq_ready=0 -> count=4, enq_ready=0, deq_pc=0x0.
REQ-034 Full queue, deq_ready=1, enq_valid=1 -> enq_ready stays 0 that cycle; next cycle count=3, enq_ready=1, deq_pc=0x4.
REQ-035 Count=2, enq and deq same cycle for 8 cycles -> count stays 2; pointers wrap; deq_pc sequence monotonic by 4.
REQ-036 Count=3, flush=1 with enq_valid=1 -> next cycle count=0, deq_valid=0, deq_inst=32'h00000013.
REQ-037 Empty, enq 32'h00500093 at PC 0x100, deq_ready=1 -> deq_valid next cycle without macro; same cycle with INST_QUEUE_BYPASS_EN, count stays 0.
REQ-038 rst_n asserted between edges with count=2 -> outputs reset immediately without a clock edge.
